// File: rtl/c2h_frame_ring_ctrl.sv
// c2h_frame_ring_ctrl: C2H DDR frame-ring write-pointer manager; frm_cnt/stall_cnt counters enabled by C2H_FRM_STAT_EN
module c2h_frame_ring_ctrl #(
   parameter logic [31:0] BUF_START = 32'h0000_0000,
   parameter logic [31:0] BUF_END   = 32'h1000_0000,
   parameter logic [31:0] BUF_SIZE  = 32'd2048,
   parameter logic [31:0] FRM_SIZE  = 32'd2048
) (
   input  logic        s_axi_aclk,
   input  logic        s_axi_aresetn,
   input  logic        soft_reset,
   input  logic [31:0] c2h_rd_next,
   output logic [31:0] c2h_wr_next,
   input  logic        frame_avail,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_addr,
   output logic [31:0] cmd_len,
   input  logic        wr_done,
   output logic        ring_full,
   output logic [31:0] frm_cnt,
   output logic [31:0] stall_cnt
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ADVANCE} state_t;
   state_t state, state_nx;
   logic [31:0] wr_ptr, next_ptr;
   logic [32:0] sum;
   assign sum       = {1'b0, wr_ptr} + {1'b0, BUF_SIZE};
   assign next_ptr  = (sum >= {1'b0, BUF_END}) ? BUF_START : sum[31:0];
   assign ring_full = next_ptr == c2h_rd_next;
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) begin
         state  <= IDLE;
         wr_ptr <= BUF_START;
      end else if (soft_reset) begin
         state  <= IDLE;
         wr_ptr <= BUF_START;
      end else begin
         state  <= state_nx;
         wr_ptr <= (state == ADVANCE) ? next_ptr : wr_ptr;
      end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = (frame_avail && !ring_full) ? ISSUE : IDLE;
         ISSUE:     state_nx = cmd_ready ? WAIT_DONE : ISSUE;
         WAIT_DONE: state_nx = wr_done ? ADVANCE : WAIT_DONE;
         default:   state_nx = IDLE;
      endcase
   end
   always_comb begin
      cmd_valid   = state == ISSUE;
      c2h_wr_next = wr_ptr;
      cmd_addr    = wr_ptr;
      cmd_len     = FRM_SIZE;
   end
`ifdef C2H_FRM_STAT_EN
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) begin
         frm_cnt   <= '0;
         stall_cnt <= '0;
      end else if (soft_reset) begin
         frm_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         frm_cnt   <= (state == ADVANCE) ? frm_cnt + 32'd1 : frm_cnt;
         stall_cnt <= (state == IDLE && frame_avail && ring_full) ? stall_cnt + 32'd1 : stall_cnt;
      end
`else
   assign frm_cnt   = '0;
   assign stall_cnt = '0;
`endif
endmodule
